// File: rtl/shape_mode_ctrl.sv
// shape_mode_ctrl: enable/start/next sequencing for the shape overlay.
// Synchronises and debounces the operator inputs, runs the OFF/READY/RUN
// state machine, steps the border animation and cycles the shape select.
//
// Build option: define LONG_PRESS_CLEAR_EN to let a long btn_next hold in
// RUN clear shape_sel back to 0 (no next_pulse for the clear).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_OFF   | enable switch low; nothing drawn, shape/animation cleared
// S_READY | enabled, outer border drawn, waiting for a start press
// S_RUN   | started; inner border animates, btn_next cycles the shape

module shape_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ANIM_PERIOD     = 50000000,
  parameter int ANIM_LAST       = 8,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sw_en,
  input  logic       btn_start,
  input  logic       btn_next,
  output logic       border_en,
  output logic       active,
  output logic [3:0] anim_step,
  output logic [1:0] shape_sel,
  output logic       next_pulse
);

  // Down-counters reload to N-1 and act when they reach zero, so N-1 must fit.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ANIM_W = (ANIM_PERIOD > 2) ? $clog2(ANIM_PERIOD) : 1;

  localparam logic [DB_W-1:0]   DB_RELOAD   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ANIM_W-1:0] ANIM_RELOAD = ANIM_W'(ANIM_PERIOD - 1);
  localparam logic [3:0]        STEP_LAST   = 4'(ANIM_LAST);

  // Reject parameter sets the counters and the 4-bit step output cannot honour.
  if (DEBOUNCE_CYCLES < 1 || ANIM_PERIOD < 1 || LONG_CYCLES < 1 ||
      ANIM_LAST < 0 || ANIM_LAST > 15) begin : g_param_check
    $error("shape_mode_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic sw_meta, sw_sync;
  logic start_meta, start_sync;
  logic next_meta, next_sync;

  logic [DB_W-1:0] start_cnt;
  logic            start_db, start_db_q;
  logic [DB_W-1:0] next_cnt;
  logic            next_db, next_db_q;

  logic start_evt;
  logic next_evt;
  logic hold_fire;

  logic [ANIM_W-1:0] anim_cnt;

  // Two-flop synchronisers for the three asynchronous operator inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta    <= 1'b0;
      sw_sync    <= 1'b0;
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      next_meta  <= 1'b0;
      next_sync  <= 1'b0;
    end else begin
      sw_meta    <= sw_en;
      sw_sync    <= sw_meta;
      start_meta <= btn_start;
      start_sync <= start_meta;
      next_meta  <= btn_next;
      next_sync  <= next_meta;
    end
  end

  // Start button debounce: accept a new level only after it has been stable
  // for the full count; any return to the accepted level reloads the timer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_cnt  <= '0;
      start_db   <= 1'b0;
      start_db_q <= 1'b0;
    end else begin
      start_db_q <= start_db;
      if (start_sync == start_db) begin
        start_cnt <= DB_RELOAD;
      end else if (start_cnt == '0) begin
        start_db  <= start_sync;
        start_cnt <= DB_RELOAD;
      end else begin
        start_cnt <= start_cnt - DB_W'(1);
      end
    end
  end

  // Next button debounce, same scheme as the start button.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      next_cnt  <= '0;
      next_db   <= 1'b0;
      next_db_q <= 1'b0;
    end else begin
      next_db_q <= next_db;
      if (next_sync == next_db) begin
        next_cnt <= DB_RELOAD;
      end else if (next_cnt == '0) begin
        next_db  <= next_sync;
        next_cnt <= DB_RELOAD;
      end else begin
        next_cnt <= next_cnt - DB_W'(1);
      end
    end
  end

  // Press events fire on the first cycle the debounced level is high.
  assign start_evt = start_db & ~start_db_q;
  assign next_evt  = next_db & ~next_db_q;

`ifdef LONG_PRESS_CLEAR_EN
  localparam int HOLD_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;

  // Long-press timer: counts debounced-high cycles of btn_next in RUN and
  // fires once per hold; releasing the button or leaving RUN re-arms it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end else if (state != S_RUN || !next_db) begin
      hold_cnt  <= HOLD_RELOAD;
      hold_done <= 1'b0;
    end else if (!hold_done) begin
      if (hold_cnt == '0) begin
        hold_done <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

  assign hold_fire = (state == S_RUN) && next_db && !hold_done && (hold_cnt == '0);
`else
  assign hold_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a low enable switch overrides every button event.
  always_comb begin
    state_nxt = state;
    if (!sw_sync) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:   state_nxt = S_READY;
        S_READY: if (start_evt) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_OFF;
      endcase
    end
  end

  // Registered border/active flags, decoded from the upcoming state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      border_en <= 1'b0;
      active    <= 1'b0;
    end else begin
      border_en <= (state_nxt != S_OFF);
      active    <= (state_nxt == S_RUN);
    end
  end

  // Animation step: period timer restarts on RUN entry, step saturates at
  // the last value, and both clear on the edge that enters OFF.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      anim_cnt  <= '0;
      anim_step <= 4'd0;
    end else if (state_nxt != S_RUN) begin
      anim_cnt  <= '0;
      anim_step <= 4'd0;
    end else if (state != S_RUN) begin
      anim_cnt  <= ANIM_RELOAD;
    end else if (anim_cnt == '0) begin
      anim_cnt <= ANIM_RELOAD;
      if (anim_step != STEP_LAST) begin
        anim_step <= anim_step + 4'd1;
      end
    end else begin
      anim_cnt <= anim_cnt - ANIM_W'(1);
    end
  end

  // Shape select: advances 1->2->3->1 on next presses while staying in RUN;
  // a press that lands while entering RUN or outside RUN is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shape_sel  <= 2'd0;
      next_pulse <= 1'b0;
    end else begin
      next_pulse <= 1'b0;
      if (state_nxt == S_OFF) begin
        shape_sel <= 2'd0;
      end else if (state == S_RUN && next_evt) begin
        shape_sel  <= (shape_sel == 2'd3) ? 2'd1 : shape_sel + 2'd1;
        next_pulse <= 1'b1;
      end else if (hold_fire) begin
        shape_sel <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_shape_mode_ctrl.sv
// Directed bench for shape_mode_ctrl with short timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_shape_mode_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       sw_en;
  logic       btn_start;
  logic       btn_next;
  logic       border_en;
  logic       active;
  logic [3:0] anim_step;
  logic [1:0] shape_sel;
  logic       next_pulse;

  int n_checks = 0;
  int n_errors = 0;

  shape_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ANIM_PERIOD    (10),
    .ANIM_LAST      (8),
    .LONG_CYCLES    (20)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sw_en     (sw_en),
    .btn_start (btn_start),
    .btn_next  (btn_next),
    .border_en (border_en),
    .active    (active),
    .anim_step (anim_step),
    .shape_sel (shape_sel),
    .next_pulse(next_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold btn_next for 'hold' cycles then release for 'gap' cycles,
  // counting cycles with next_pulse high.
  task automatic press_next(input int hold, input int gap, output int pulses);
    pulses = 0;
    btn_next = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      if (next_pulse) pulses++;
    end
    btn_next = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick(1);
      if (next_pulse) pulses++;
    end
  endtask

  // Press btn_start (held 8 cycles) and return cycles until active, 20 = timeout.
  task automatic press_start(output int lat);
    lat = 20;
    btn_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 8) btn_start = 1'b0;
      if (active && lat == 20) lat = i;
    end
    btn_start = 1'b0;
  endtask

  int lat;
  int pulses;
  int t3;
  int t0;
  int exp_shape[5] = '{1, 2, 3, 1, 2};

  initial begin
    resetn    = 1'b0;
    sw_en     = 1'b0;
    btn_start = 1'b0;
    btn_next  = 1'b0;
    tick(3);
    chk("rst_border", border_en, 0);
    chk("rst_active", active, 0);
    chk("rst_step", anim_step, 0);
    chk("rst_shape", shape_sel, 0);
    chk("rst_pulse", next_pulse, 0);

    // Enable: border appears three edges after sw_en rises.
    resetn = 1'b1;
    sw_en  = 1'b1;
    lat = 10;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (border_en && lat == 10) lat = i;
    end
    chk("en_border_lat", lat, 3);
    chk("ready_active", active, 0);
    chk("ready_step", anim_step, 0);

    // btn_next in READY is ignored.
    press_next(8, 8, pulses);
    chk("ready_next_pulses", pulses, 0);
    chk("ready_next_shape", shape_sel, 0);
    chk("ready_next_active", active, 0);

    // Two-cycle glitches on btn_start must not start.
    for (int g = 0; g < 2; g++) begin
      btn_start = 1'b1;
      tick(2);
      btn_start = 1'b0;
      tick(3);
    end
    tick(8);
    chk("glitch_active", active, 0);

    // Clean press: 2 sync + 4 debounce + event + state register = 7 edges.
    press_start(lat);
    chk("start_lat", lat, 7);
    // press_start ran 13 more cycles after entry; step 1 is at entry+10.
    chk("anim_after13", anim_step, 1);
    tick(6);
    chk("anim_19", anim_step, 1);
    tick(1);
    chk("anim_20", anim_step, 2);
    tick(59);
    chk("anim_79", anim_step, 7);
    tick(1);
    chk("anim_80", anim_step, 8);
    tick(20);
    chk("anim_sat", anim_step, 8);

    // Five clean next presses: 1,2,3,1,2 with one strobe each.
    for (int p = 0; p < 5; p++) begin
      press_next(8, 8, pulses);
      chk($sformatf("next%0d_pulses", p), pulses, 1);
      chk($sformatf("next%0d_shape", p), shape_sel, exp_shape[p]);
    end

    // Long hold from shape 2.
    pulses = 0;
    t3 = -1;
    t0 = -1;
    btn_next = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick(1);
      if (i == 30) btn_next = 1'b0;
      if (next_pulse) pulses++;
      if (shape_sel == 2'd3 && t3 < 0) t3 = i;
      if (t3 >= 0 && shape_sel == 2'd0 && t0 < 0) t0 = i;
    end
    btn_next = 1'b0;
    chk("long_pulses", pulses, 1);
    chk("long_saw3", (t3 >= 0) ? 1 : 0, 1);
`ifdef LONG_PRESS_CLEAR_EN
    chk("long_clear_delay", t0 - t3, 19);
    chk("long_final_shape", shape_sel, 0);
    for (int p = 0; p < 3; p++) press_next(8, 8, pulses);
`else
    chk("long_no_clear", (t0 < 0) ? 1 : 0, 1);
    chk("long_final_shape", shape_sel, 3);
`endif
    chk("pre_off_shape", shape_sel, 3);

    // Disable: OFF three edges after sw_en falls, everything cleared.
    sw_en = 1'b0;
    tick(2);
    chk("off_border_pre", border_en, 1);
    tick(1);
    chk("off_border", border_en, 0);
    chk("off_active", active, 0);
    chk("off_shape", shape_sel, 0);
    chk("off_step", anim_step, 0);

    // Re-enable lands in READY; a fresh start is needed.
    sw_en = 1'b1;
    tick(8);
    chk("reen_border", border_en, 1);
    chk("reen_active", active, 0);
    press_start(lat);
    chk("restart_lat", lat, 7);
    chk("restart_shape", shape_sel, 0);

    // Start and next accepted in the same cycle in READY: next dropped.
    sw_en = 1'b0;
    tick(5);
    sw_en = 1'b1;
    tick(6);
    pulses = 0;
    btn_start = 1'b1;
    btn_next  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i == 8) begin
        btn_start = 1'b0;
        btn_next  = 1'b0;
      end
      if (next_pulse) pulses++;
    end
    chk("both_active", active, 1);
    chk("both_shape", shape_sel, 0);
    chk("both_pulses", pulses, 0);

    // Asynchronous reset mid-animation.
    tick(15);
    chk("pre_rst_step", anim_step, 2);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_border", border_en, 0);
    chk("async_rst_active", active, 0);
    chk("async_rst_step", anim_step, 0);
    tick(2);
    resetn = 1'b1;
    lat = 10;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (border_en && lat == 10) lat = i;
    end
    chk("post_rst_border_lat", lat, 3);
    chk("post_rst_active", active, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shape_mode_ctrl.md
SHAPE_MODE_CTRL -- requirements
Module: shape_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of stable clk cycles before a button level is accepted (5 ms at 100 MHz).
REQ-002 SHALL have parameter ANIM_PERIOD, default 50000000, meaning the number of clk cycles per animation step (2 Hz at 100 MHz).
REQ-003 SHALL have parameter ANIM_LAST, default 8, meaning the final animation step value.
REQ-004 SHALL have parameter LONG_CYCLES, default 100000000, meaning the hold time for a long press (1 s).
REQ-005 SHALL have port clk, input, 1 bit: the 100 MHz system clock; all state is on the rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sw_en, input, 1 bit: the enable switch, asynchronous to clk.
REQ-008 SHALL have port btn_start, input, 1 bit: the raw centre button, asynchronous to clk.
REQ-009 SHALL have port btn_next, input, 1 bit: the raw down button, asynchronous to clk.
REQ-010 SHALL have port border_en, output, 1 bit: the outer border is drawn.
REQ-011 SHALL have port active, output, 1 bit: start has been accepted, so the inner border and animation are drawn.
REQ-012 SHALL have port anim_step, output, 4 bits: the current border-animation step.
REQ-013 SHALL have port shape_sel, output, 2 bits: 0 = none, 1 = square, 2 = circle, 3 = triangle.
REQ-014 SHALL have port next_pulse, output, 1 bit: a one-cycle strobe for each accepted btn_next press.

Function
REQ-015 SHALL pass sw_en, btn_start and btn_next each through a 2-flop synchronizer; the input-to-synchronized latency is 2 cycles.
REQ-016 SHALL debounce each button with its own counter: the accepted level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level, and any mismatch reloads the counter.
REQ-017 SHALL generate a press event on the cycle the debounced level goes 0->1, and only then; a held button generates no further events.
REQ-018 SHALL implement an FSM with states OFF, READY and RUN.
- OFF -> READY when sync sw_en = 1.
- READY -> RUN on a btn_start event.
- Any state -> OFF when sync sw_en = 0.
REQ-019 SHALL drive border_en = 1 in READY and RUN, and active = 1 only in RUN, each as a registered output.
REQ-020 SHALL hold anim_step at 0 outside RUN; in RUN it increments once every ANIM_PERIOD cycles and saturates at ANIM_LAST.
REQ-021 SHALL clear the anim period counter on RUN entry so the first increment occurs exactly ANIM_PERIOD cycles after entry.
REQ-022 SHALL advance shape_sel on a btn_next event only in RUN: 0->1->2->3->1 (wraps to 1, never back to 0).
REQ-023 SHALL ignore btn_next events outside RUN; next_pulse stays 0 and shape_sel is unchanged.
REQ-024 SHALL assert next_pulse for exactly one cycle, coincident with the shape_sel update.
REQ-025 SHALL force shape_sel to 0 and anim_step to 0 on any transition to OFF, taking effect on the same edge as the state change.
REQ-026 SHALL, when a btn_start and a btn_next event fall in the same cycle in READY, enter RUN with shape_sel = 0; the btn_next event is dropped.
REQ-027 SHALL give sw_en deasserting the same cycle as any button event priority to OFF.
REQ-028 SHALL treat btn_start events in RUN as no-ops.

Reset
REQ-029 SHALL, when resetn = 0, asynchronously force state = OFF, border_en = 0, active = 0, anim_step = 0, shape_sel = 0, next_pulse = 0, all synchronizers to 0, debounced levels to 0, and all counters to 0.
REQ-030 SHALL, when reset asserts mid-debounce or mid-animation, discard progress; after release, the block behaves as from power-up.

Configuration
REQ-031 SHALL, with LONG_PRESS_CLEAR_EN defined, set shape_sel to 0 in RUN when btn_next stays debounced-high for LONG_CYCLES consecutive cycles, once per hold, without asserting next_pulse; the initial press still advances normally.
REQ-032 SHALL, with LONG_PRESS_CLEAR_EN undefined, exclude the hold counter and leave holding btn_next with no effect beyond the initial press.

Verification (bench parameters: DEBOUNCE_CYCLES=4, ANIM_PERIOD=10, ANIM_LAST=8, LONG_CYCLES=20)
REQ-033 SHALL cover: resetn low, then sw_en=1 -> border_en=1 and active=0 on the 3rd or 4th cycle after release of sw_en sync; anim_step=0.
REQ-034 SHALL cover: in READY, btn_start with 2-cycle glitches, then held for 6 cycles -> no RUN from glitches; active=1 after the held press is debounced; anim_step reaches 1 exactly 10 cycles later and saturates at 8 after 80 cycles.
REQ-035 SHALL cover: in RUN, 5 clean btn_next presses -> shape_sel 1,2,3,1,2 and 5 single-cycle next_pulse strobes.
REQ-036 SHALL cover: shape_sel=3, then sw_en=0 -> next state OFF with shape_sel=0, anim_step=0, active=0, border_en=0; re-enabling requires a new btn_start.
REQ-037 SHALL cover: btn_next pressed in READY -> shape_sel stays 0 and no next_pulse.
REQ-038 SHALL cover, with LONG_PRESS_CLEAR_EN: shape_sel=2, btn_next held 30 cycles -> shape_sel=3 on press, then 0 after 20 debounced-high cycles, with a single next_pulse; without the macro, shape_sel stays 3.
